// File: rtl/fir_direct_mac_param.sv
// fir_direct_mac_param
//   Direct-form FIR filter sharing one multiplier across NTAP taps. Coefficients
//   sit in a runtime-writable register file. Valid/ready handshakes are used on
//   both the sample input and the filtered output.
//
//   Optional build macro: FIR_SAT_EN
//     defined   -> output saturates to the signed OW-bit range
//     undefined -> output takes the low OW bits (two's-complement wrap)
//
// Ports
//   iClk_12M    clock, rising edge
//   iRst        asynchronous, active-high reset
//   iInValid    input sample valid
//   oInReady    block can accept a sample (high only while idle)
//   iFirIn      signed input sample, DW bits
//   iCoeffWe    coefficient write strobe
//   iCoeffAddr  coefficient index k (coeff[k] multiplies x[n-k])
//   iCoeffData  signed coefficient value, CW bits
//   oCoeffErr   one-cycle pulse when a coefficient write is dropped
//   oOutValid   oFirOut valid, held until accepted
//   iOutReady   downstream accepts oFirOut
//   oFirOut     signed filtered output, OW bits
module fir_direct_mac_param #(
    parameter int unsigned NTAP  = 33,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned OW    = 16,
    parameter int unsigned SHIFT = 15
) (
    input  logic                     iClk_12M,
    input  logic                     iRst,
    input  logic                     iInValid,
    output logic                     oInReady,
    input  logic [DW-1:0]            iFirIn,
    input  logic                     iCoeffWe,
    input  logic [$clog2(NTAP)-1:0]  iCoeffAddr,
    input  logic [CW-1:0]            iCoeffData,
    output logic                     oCoeffErr,
    output logic                     oOutValid,
    input  logic                     iOutReady,
    output logic [OW-1:0]            oFirOut
);

    localparam int unsigned AW   = $clog2(NTAP);
    localparam int unsigned PW   = DW + CW;
    localparam int unsigned ACCW = PW + AW;

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t                      state_q, state_d;
    logic [NTAP-1:0][DW-1:0]     tap_q;
    logic [NTAP-1:0][CW-1:0]     coeff_q;
    logic signed [ACCW-1:0]      acc_q;
    logic [AW-1:0]               k_q;

    logic                        accept_c;
    logic                        coeff_ok_c;
    logic                        coeff_err_c;
    logic                        addr_ok_c;
    logic signed [PW-1:0]        prod_c;
    logic signed [ACCW-1:0]      r_c;
    logic [OW-1:0]               fmt_c;

    // Next-state and handshake decode
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        coeff_ok_c  = 1'b0;
        coeff_err_c = 1'b0;
        addr_ok_c   = ({1'b0, iCoeffAddr} < (AW+1)'(NTAP));
        unique case (state_q)
            IDLE: begin
                if (iInValid) begin
                    accept_c = 1'b1;
                    state_d  = MAC;
                end
            end
            MAC: begin
                if (k_q == AW'(NTAP - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: state_d = OUT;
            OUT: begin
                if (iOutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Writes land only while idle; the MAC never sees a coefficient change mid-sum
        if (iCoeffWe) begin
            if ((state_q == IDLE) && addr_ok_c) begin
                coeff_ok_c = 1'b1;
            end else begin
                coeff_err_c = 1'b1;
            end
        end
    end

    // One product per MAC cycle
    assign prod_c = $signed(coeff_q[k_q]) * $signed(tap_q[k_q]);

    // Round half up, then arithmetic shift
    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (SHIFT - 1);
        logic signed [ACCW-1:0] biased;
        assign biased = acc_q + HALF;
        assign r_c    = biased >>> SHIFT;
    end else begin : g_pass
        assign r_c = acc_q;
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACCW-1:0] OMAX = $signed({{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [ACCW-1:0] OMIN = ~OMAX;

    // Clamp to the signed output range
    always_comb begin
        if (r_c > OMAX) begin
            fmt_c = OW'(OMAX);
        end else if (r_c < OMIN) begin
            fmt_c = OW'(OMIN);
        end else begin
            fmt_c = OW'(r_c);
        end
    end
`else
    // Two's-complement wrap to the output width
    assign fmt_c = OW'(r_c);
`endif

    // State and output registers
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state_q   <= IDLE;
            oInReady  <= 1'b1;
            oOutValid <= 1'b0;
            oFirOut   <= '0;
            oCoeffErr <= 1'b0;
        end else begin
            state_q   <= state_d;
            oInReady  <= (state_d == IDLE);
            oCoeffErr <= coeff_err_c;
            if (state_q == ROUND) begin
                oOutValid <= 1'b1;
                oFirOut   <= fmt_c;
            end else if ((state_q == OUT) && iOutReady) begin
                oOutValid <= 1'b0;
            end
        end
    end

    // Tap line, coefficient file, accumulator
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            tap_q   <= '0;
            coeff_q <= '0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            if (coeff_ok_c) begin
                coeff_q[iCoeffAddr] <= iCoeffData;
            end
            if (accept_c) begin
                tap_q <= {tap_q[NTAP-2:0], iFirIn};
                acc_q <= '0;
                k_q   <= '0;
            end else if (state_q == MAC) begin
                acc_q <= acc_q + ACCW'(prod_c);
                k_q   <= k_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_direct_mac_param.sv
`timescale 1ns/1ps
module tb_fir_direct_mac_param;

    localparam int NTAP = 33;
    localparam int LAT  = NTAP + 1;

    logic        iClk_12M;
    logic        iRst;
    logic        iInValid;
    logic        oInReady;
    logic [15:0] iFirIn;
    logic        iCoeffWe;
    logic [5:0]  iCoeffAddr;
    logic [15:0] iCoeffData;
    logic        oCoeffErr;
    logic        oOutValid;
    logic        iOutReady;
    logic [15:0] oFirOut;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [15:0] m_tap  [NTAP];
    logic signed [15:0] m_coef [NTAP];

    fir_direct_mac_param dut (
        .iClk_12M   (iClk_12M),
        .iRst       (iRst),
        .iInValid   (iInValid),
        .oInReady   (oInReady),
        .iFirIn     (iFirIn),
        .iCoeffWe   (iCoeffWe),
        .iCoeffAddr (iCoeffAddr),
        .iCoeffData (iCoeffData),
        .oCoeffErr  (oCoeffErr),
        .oOutValid  (oOutValid),
        .iOutReady  (iOutReady),
        .oFirOut    (oFirOut)
    );

    initial iClk_12M = 1'b0;
    always #42 iClk_12M = ~iClk_12M;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_clear();
        for (int k = 0; k < NTAP; k++) begin
            m_tap[k]  = '0;
            m_coef[k] = '0;
        end
    endfunction

    // Shift in a sample and return the expected output (SHIFT=15, OW=16)
    function automatic logic [15:0] model_push(input logic [15:0] s);
        longint acc;
        for (int k = NTAP - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
        m_tap[0] = s;
        acc = 0;
        for (int k = 0; k < NTAP; k++) acc += longint'(m_coef[k]) * longint'(m_tap[k]);
        acc = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
        if (acc > 64'sd32767) acc = 64'sd32767;
        else if (acc < -64'sd32768) acc = -64'sd32768;
`endif
        return acc[15:0];
    endfunction

    task automatic write_coeff(input int addr, input logic [15:0] data);
        @(negedge iClk_12M);
        iCoeffWe   = 1'b1;
        iCoeffAddr = 6'(addr);
        iCoeffData = data;
        @(negedge iClk_12M);
        iCoeffWe = 1'b0;
        if (addr < NTAP) m_coef[addr] = data;
    endtask

    // Offer a sample and return one clock edge after it was taken
    task automatic accept(input logic [15:0] s, output bit ok);
        int n;
        n = 0;
        @(negedge iClk_12M);
        while (!oInReady && n < 200) begin
            @(negedge iClk_12M);
            n++;
        end
        ok = oInReady;
        iFirIn   = s;
        iInValid = 1'b1;
        @(posedge iClk_12M);
        #1;
        iInValid = 1'b0;
    endtask

    // Count edges after the accept until oOutValid; complete the handshake if ready
    task automatic wait_out(input int start, output logic [15:0] y, output int lat, output bit got);
        lat = start;
        got = 1'b0;
        while (!got && lat < start + 100) begin
            @(posedge iClk_12M);
            #1;
            lat++;
            got = oOutValid;
        end
        y = oFirOut;
        if (got && iOutReady) begin
            @(posedge iClk_12M);
            #1;
        end
    endtask

    task automatic run(input logic [15:0] s, output logic [15:0] y, output int lat, output bit ok);
        bit a, g;
        accept(s, a);
        wait_out(0, y, lat, g);
        ok = a && g;
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (3) @(negedge iClk_12M);
        n_tests++; if (oOutValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", oOutValid); end
        n_tests++; if (oFirOut !== 16'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0000", oFirOut); end
        n_tests++; if (oCoeffErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", oCoeffErr); end
        iRst = 1'b0;
        model_clear();
        @(negedge iClk_12M);
        n_tests++; if (oInReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", oInReady); end
        n_tests++; if (oOutValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_post: got %b expected 0", oOutValid); end
    endtask

    // coeff[k]=2(k+1) with impulse 2^14 gives (k+1) after the >>15
    task automatic test_impulse();
        logic [15:0] y, s;
        int lat;
        bit ok;
        for (int k = 0; k < NTAP; k++) write_coeff(k, 16'(2 * (k + 1)));
        for (int i = 0; i < NTAP; i++) begin
            s = (i == 0) ? 16'h4000 : 16'h0000;
            void'(model_push(s));
            run(s, y, lat, ok);
            n_tests++;
            if (!ok || y !== 16'(i + 1)) begin n_fail++; $display("FAIL impulse_out[%0d]: got %h expected %h", i, y, 16'(i + 1)); end
            n_tests++;
            if (lat != LAT) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] y, e, last_pos, last_neg;
        int lat;
        bit ok;
`ifdef FIR_SAT_EN
        last_pos = 16'h7FFF;
        last_neg = 16'h8000;
`else
        last_pos = 16'h7FBE;
        last_neg = 16'h8021;
`endif
        for (int k = 0; k < NTAP; k++) write_coeff(k, 16'h7FFF);
        for (int i = 0; i < NTAP; i++) begin
            e = model_push(16'h7FFF);
            run(16'h7FFF, y, lat, ok);
            n_tests++;
            if (!ok || y !== e) begin n_fail++; $display("FAIL overflow_pos[%0d]: got %h expected %h", i, y, e); end
        end
        n_tests++; if (y !== last_pos) begin n_fail++; $display("FAIL overflow_pos_final: got %h expected %h", y, last_pos); end
        for (int i = 0; i < NTAP; i++) begin
            e = model_push(16'h8000);
            run(16'h8000, y, lat, ok);
            n_tests++;
            if (!ok || y !== e) begin n_fail++; $display("FAIL overflow_neg[%0d]: got %h expected %h", i, y, e); end
        end
        n_tests++; if (y !== last_neg) begin n_fail++; $display("FAIL overflow_neg_final: got %h expected %h", y, last_neg); end
    endtask

    task automatic load_mixed_coeffs();
        for (int k = 0; k < NTAP; k++)
            write_coeff(k, (k % 2 == 0) ? 16'(500 * k + 300) : 16'(-(500 * k + 300)));
    endtask

    task automatic test_backpressure();
        logic [15:0] y0, y, e;
        int lat;
        bit a, g;
        load_mixed_coeffs();
        iOutReady = 1'b0;
        e = model_push(16'h1234);
        accept(16'h1234, a);
        wait_out(0, y0, lat, g);
        n_tests++; if (!(a && g) || y0 !== e) begin n_fail++; $display("FAIL bp_first: got %h expected %h", y0, e); end
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk_12M);
            iFirIn   = 16'h5555;
            iInValid = 1'b1;
            @(posedge iClk_12M);
            #1;
            n_tests++; if (oOutValid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, oOutValid); end
            n_tests++; if (oFirOut !== y0) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, oFirOut, y0); end
            n_tests++; if (oInReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, oInReady); end
        end
        iInValid  = 1'b0;
        iOutReady = 1'b1;
        @(posedge iClk_12M);
        #1;
        n_tests++; if (oOutValid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", oOutValid); end
        n_tests++; if (oInReady !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b expected 1", oInReady); end
        // The offered 0x5555 must not have entered the tap line
        e = model_push(16'h0100);
        run(16'h0100, y, lat, a);
        n_tests++; if (!a || y !== e) begin n_fail++; $display("FAIL bp_next: got %h expected %h", y, e); end
    endtask

    task automatic test_coeff_err();
        logic [15:0] y, e;
        int lat;
        bit a, g;
        e = model_push(16'h0800);
        accept(16'h0800, a);
        @(negedge iClk_12M);
        iCoeffWe   = 1'b1;
        iCoeffAddr = 6'd3;
        iCoeffData = 16'h7000;
        @(posedge iClk_12M);
        #1;
        iCoeffWe = 1'b0;
        n_tests++; if (oCoeffErr !== 1'b1) begin n_fail++; $display("FAIL err_busy_pulse: got %b expected 1", oCoeffErr); end
        @(posedge iClk_12M);
        #1;
        n_tests++; if (oCoeffErr !== 1'b0) begin n_fail++; $display("FAIL err_busy_single: got %b expected 0", oCoeffErr); end
        wait_out(2, y, lat, g);
        n_tests++; if (!(a && g) || y !== e) begin n_fail++; $display("FAIL err_busy_out: got %h expected %h", y, e); end
        @(negedge iClk_12M);
        iCoeffWe   = 1'b1;
        iCoeffAddr = 6'd40;
        iCoeffData = 16'h7777;
        @(posedge iClk_12M);
        #1;
        iCoeffWe = 1'b0;
        n_tests++; if (oCoeffErr !== 1'b1) begin n_fail++; $display("FAIL err_addr_pulse: got %b expected 1", oCoeffErr); end
        @(posedge iClk_12M);
        #1;
        n_tests++; if (oCoeffErr !== 1'b0) begin n_fail++; $display("FAIL err_addr_single: got %b expected 0", oCoeffErr); end
        @(negedge iClk_12M);
        iCoeffWe   = 1'b1;
        iCoeffAddr = 6'd5;
        iCoeffData = 16'h0123;
        @(posedge iClk_12M);
        #1;
        iCoeffWe  = 1'b0;
        m_coef[5] = 16'h0123;
        n_tests++; if (oCoeffErr !== 1'b0) begin n_fail++; $display("FAIL err_valid_write: got %b expected 0", oCoeffErr); end
        e = model_push(16'h0400);
        run(16'h0400, y, lat, a);
        n_tests++; if (!a || y !== e) begin n_fail++; $display("FAIL err_next_out: got %h expected %h", y, e); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] y;
        int lat;
        bit a, seen;
        accept(16'h2000, a);
        repeat (9) @(posedge iClk_12M);
        #1;
        iRst = 1'b1;
        #1;
        n_tests++; if (oOutValid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", oOutValid); end
        n_tests++; if (oFirOut !== 16'h0) begin n_fail++; $display("FAIL mid_rst_out: got %h expected 0000", oFirOut); end
        n_tests++; if (oCoeffErr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b expected 0", oCoeffErr); end
        repeat (3) @(negedge iClk_12M);
        iRst = 1'b0;
        model_clear();
        @(negedge iClk_12M);
        n_tests++; if (oInReady !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", oInReady); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iClk_12M);
            if (oOutValid) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_abort: got %b expected 0", seen); end
        // Coefficients were cleared
        void'(model_push(16'h4000));
        run(16'h4000, y, lat, a);
        n_tests++; if (!a || y !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_coeffs: got %h expected 0000", y); end
        // Taps were cleared: only pre-reset history could reach coeff[2..]
        for (int k = 2; k < NTAP; k++) write_coeff(k, 16'h7FFF);
        void'(model_push(16'h0000));
        run(16'h0000, y, lat, a);
        n_tests++; if (!a || y !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_taps: got %h expected 0000", y); end
    endtask

    task automatic test_streaming();
        logic [15:0] y, e, s;
        int lat;
        bit ok;
        for (int k = 0; k < NTAP; k++) write_coeff(k, 16'($urandom));
        for (int i = 0; i < 200; i++) begin
            s = 16'($urandom);
            e = model_push(s);
            run(s, y, lat, ok);
            n_tests++;
            if (!ok || y !== e) begin n_fail++; $display("FAIL stream[%0d]: in %h got %h expected %h", i, s, y, e); end
        end
    endtask

    initial begin
        iRst       = 1'b1;
        iInValid   = 1'b0;
        iFirIn     = '0;
        iCoeffWe   = 1'b0;
        iCoeffAddr = '0;
        iCoeffData = '0;
        iOutReady  = 1'b1;
        model_clear();
        test_reset();
        test_impulse();
        test_overflow();
        test_backpressure();
        test_coeff_err();
        test_reset_mid();
        test_streaming();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
